// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: datapath sizes and load funct3 encodings.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 16;
    localparam int LQ_DEPTH   = 4;
    localparam int REG_ADDR_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Formats a raw aligned memory word into a load result: lane select plus sign/zero extension.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_offset,
    input  logic [DATA_W-1:0] i_word,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Halfword lane comes from offset[1] alone; offset[0] is ignored.
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates load responses and ALU results onto the single register
// write port, tracks outstanding loads in an in-order queue and publishes a busy mask.
module writeback_stage #(
    parameter int XLEN     = wb_pkg::XLEN,
    parameter int NREG     = wb_pkg::NREG,
    parameter int LQ_DEPTH = wb_pkg::LQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         ld_issue_valid,
    output logic                         ld_issue_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] ld_issue_rd,
    input  logic [2:0]                   ld_issue_funct3,
    input  logic [1:0]                   ld_issue_offset,
    input  logic                         mem_rsp_valid,
    input  logic [XLEN-1:0]              mem_rsp_data,
    output logic [wb_pkg::REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]              rd_data,
    output logic [NREG-1:0]              busy_mask,
    output logic [$clog2(LQ_DEPTH):0]    lq_count,
    output logic                         err_proto
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RW    = wb_pkg::REG_ADDR_W;

    logic [RW-1:0]    r_lq_rd  [LQ_DEPTH];
    logic [2:0]       r_lq_f3  [LQ_DEPTH];
    logic [1:0]       r_lq_off [LQ_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [NREG-1:0]  r_busy;
    logic [RW-1:0]    r_rd_addr;
    logic [XLEN-1:0]  r_rd_data;
    logic             r_err;

    logic             w_push;
    logic             w_pop;
    logic             w_alu_acc;
    logic [RW-1:0]    w_head_rd;
    logic [XLEN-1:0]  w_ld_data;
    logic             w_head_shared;
    logic [PTR_W-1:0] w_scan_idx;
    logic [NREG-1:0]  w_busy_next;

    assign ld_issue_ready = (r_count < CNT_W'(LQ_DEPTH));
    assign w_push         = ld_issue_valid && ld_issue_ready;
    assign w_pop          = mem_rsp_valid && (r_count != '0);
    assign alu_ready      = !w_pop;
    assign w_alu_acc      = alu_valid && alu_ready;
    assign w_head_rd      = r_lq_rd[r_rd_ptr];

    wb_load_align #(.DATA_W(XLEN)) u_align (
        .i_funct3 (r_lq_f3[r_rd_ptr]),
        .i_offset (r_lq_off[r_rd_ptr]),
        .i_word   (mem_rsp_data),
        .o_data   (w_ld_data)
    );

    // The head's busy bit survives a pop if any younger entry, or the load being pushed
    // this cycle, targets the same register.
    always_comb begin
        w_head_shared = 1'b0;
        w_scan_idx    = r_rd_ptr;
        for (int k = 1; k < LQ_DEPTH; k++) begin
            w_scan_idx = r_rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_lq_rd[w_scan_idx] == w_head_rd))
                w_head_shared = 1'b1;
        end
        if (w_push && (ld_issue_rd == w_head_rd))
            w_head_shared = 1'b1;
    end

    always_comb begin
        w_busy_next = r_busy;
        if (w_pop && !w_head_shared)
            w_busy_next[w_head_rd] = 1'b0;
        if (w_push && (ld_issue_rd != '0))
            w_busy_next[ld_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq_rd[r_wr_ptr]  <= ld_issue_rd;
            r_lq_f3[r_wr_ptr]  <= ld_issue_funct3;
            r_lq_off[r_wr_ptr] <= ld_issue_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_busy <= w_busy_next;
            if ((mem_rsp_valid && (r_count == '0)) ||
                (ld_issue_valid && !ld_issue_ready) ||
                (w_alu_acc && r_busy[alu_rd]))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else if (w_pop) begin
            r_rd_addr <= w_head_rd;
            r_rd_data <= w_ld_data;
        end else if (w_alu_acc) begin
            r_rd_addr <= alu_rd;
            r_rd_data <= alu_data;
        end else begin
            r_rd_addr <= '0;
        end
    end

    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;
    assign busy_mask = r_busy;
    assign lq_count  = r_count;
    assign err_proto = r_err;

endmodule
